// File: rtl/hls_if_pkg.sv
// Shared types and constants for the HLS result reader block.
// No logic; only compile-time definitions.
// No flow control; only compile-time definitions.
package hls_if_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   localparam int RESULT_W = 32;
   localparam int SYM_W    = 2;
   localparam int NUM_SYM  = RESULT_W / SYM_W;

   // Watchdog counter width for a given abort limit
   function automatic int wd_width(input int timeout);
      return (timeout > 2) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/hls_result_reader_sym_serializer.sv
// Holds a captured result word and emits it LSB-first, SYM_W bits per beat.
// Latency: first symbol valid the cycle after load; one symbol per accepted beat.
// Backpressure: symbol and index hold while sym_valid & !sym_ready.
module sym_serializer #(
   parameter int RESULT_W = 32,
   parameter int SYM_W    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [RESULT_W-1:0] load_dat,
   output logic                sym_valid,
   output logic [SYM_W-1:0]    sym_data,
   input  logic                sym_ready,
   output logic                done
);
   import hls_if_pkg::*;

   localparam int N     = RESULT_W / SYM_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   logic [RESULT_W-1:0] result_q, result_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                valid_q, valid_d;

   // The result shifts right on each accept, so the current symbol always
   // sits in the low bits and comes straight from a flop.
   always_comb begin
      result_d = result_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      done     = 1'b0;
      if (load) begin
         result_d = load_dat;
         idx_d    = '0;
         valid_d  = 1'b1;
      end else if (valid_q && sym_ready) begin
         result_d = result_q >> SYM_W;
         if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            valid_d = 1'b0;
            done    = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // State registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         result_q <= '0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
      end
   end

   assign sym_valid = valid_q;
   assign sym_data  = result_q[SYM_W-1:0];

endmodule

// File: rtl/hls_result_reader.sv
// Starts an HLS core, waits for finish under a watchdog, streams the result as symbols.
// Latency: start one cycle after trigger; first symbol one cycle after finish.
// Backpressure: symbol stream stalls on !sym_ready; waitrequest mirrors stall_i.
module hls_result_reader #(
   parameter int RESULT_W = hls_if_pkg::RESULT_W,
   parameter int SYM_W    = hls_if_pkg::SYM_W,
   parameter int TIMEOUT  = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                trigger,
   output logic                start,
   input  logic                stall_i,
   output logic                waitrequest,
   input  logic                finish,
   input  logic [RESULT_W-1:0] return_val,
   output logic                sym_valid,
   output logic [SYM_W-1:0]    sym_data,
   input  logic                sym_ready,
   output logic                busy,
   output logic                timeout_o,
   output logic [7:0]          run_count
);
   import hls_if_pkg::*;

   localparam int WD_W = wd_width(TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [7:0]      run_q, run_d;
   logic            start_q, start_d;
   logic            busy_q, busy_d;
   logic            timeout_q, timeout_d;
   logic            load;
   logic            done;

   // Next-state, watchdog and run counter; finish beats a same-cycle timeout
   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      run_d     = run_q;
      timeout_d = 1'b0;
      load      = 1'b0;
      case (state_q)
         IDLE: begin
            if (trigger) state_d = START;
         end
         START: begin
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wd_d = wd_q + 1'b1;
            if (finish) begin
               load    = 1'b1;
               state_d = DRAIN;
            end else if (wd_q == WD_MAX) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end
         end
         DRAIN: begin
            if (done) begin
               state_d = IDLE;
               run_d   = run_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      start_d = (state_d == START);
      busy_d  = (state_d != IDLE);
   end

   // FSM and registered status outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         wd_q      <= '0;
         run_q     <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_q      <= wd_d;
         run_q     <= run_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   sym_serializer #(
      .RESULT_W (RESULT_W),
      .SYM_W    (SYM_W)
   ) u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_dat  (return_val),
      .sym_valid (sym_valid),
      .sym_data  (sym_data),
      .sym_ready (sym_ready),
      .done      (done)
   );

   assign waitrequest = stall_i;
   assign start       = start_q;
   assign busy        = busy_q;
   assign timeout_o   = timeout_q;
   assign run_count   = run_q;

endmodule

// File: tb/tb_hls_result_reader.sv
// Scoreboard bench for hls_result_reader (TIMEOUT=8 so the watchdog is reachable).
// Expected symbols are queued when finish is driven; a monitor pops on each accept.
// Backpressure is exercised by dropping sym_ready mid-drain.
module tb_hls_result_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        trigger = 1'b0;
   logic        start;
   logic        stall_i = 1'b0;
   logic        waitrequest;
   logic        finish = 1'b0;
   logic [31:0] return_val = '0;
   logic        sym_valid;
   logic [1:0]  sym_data;
   logic        sym_ready = 1'b1;
   logic        busy;
   logic        timeout_o;
   logic [7:0]  run_count;

   int          checks = 0;
   int          errors = 0;
   logic [1:0]  exp_q[$];
   logic [7:0]  rc_exp = 8'd0;

   always #5 clk = ~clk;

   hls_result_reader #(.RESULT_W(32), .SYM_W(2), .TIMEOUT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .trigger     (trigger),
      .start       (start),
      .stall_i     (stall_i),
      .waitrequest (waitrequest),
      .finish      (finish),
      .return_val  (return_val),
      .sym_valid   (sym_valid),
      .sym_data    (sym_data),
      .sym_ready   (sym_ready),
      .busy        (busy),
      .timeout_o   (timeout_o),
      .run_count   (run_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_syms(input logic [31:0] v);
      for (int i = 0; i < 16; i++) exp_q.push_back(v[2*i +: 2]);
   endtask

   // Pops one expected symbol per accepted beat and checks stall stability
   task automatic monitor();
      logic       prev_stall = 1'b0;
      logic [1:0] prev_dat = 2'd0;
      logic [1:0] e;
      forever begin
         @(negedge clk);
         if (!reset || !sym_valid) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) chk("sym_hold", 32'(sym_data), 32'(prev_dat));
            if (sym_ready) begin
               chk("sym_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("sym_data", 32'(sym_data), 32'(e));
               end
            end
            prev_stall = !sym_ready;
            prev_dat   = sym_data;
         end
      end
   endtask

   // Trigger a run and drive finish lat cycles after start
   task automatic start_and_finish(input logic [31:0] v, input int lat);
      trigger = 1'b1;
      step();
      chk("start_pulse", 32'(start), 32'd1);
      chk("busy_start", 32'(busy), 32'd1);
      trigger = 1'b0;
      step();
      chk("start_one_cycle", 32'(start), 32'd0);
      for (int i = 1; i < lat; i++) step();
      finish = 1'b1;
      return_val = v;
      push_syms(v);
      step();
      finish = 1'b0;
      chk("first_sym_valid", 32'(sym_valid), 32'd1);
   endtask

   // Drain with optional stall of stall_cyc cycles while symbol stall_sym is presented
   task automatic drain(input int stall_sym, input int stall_cyc);
      int  accepted = 0;
      int  stall_left = stall_cyc;
      int  cyc = 0;
      logic acc;
      while (busy && cyc < 100) begin
         if (accepted == stall_sym && stall_left > 0) begin
            sym_ready = 1'b0;
            stall_left--;
            chk("stall_valid", 32'(sym_valid), 32'd1);
         end else begin
            sym_ready = 1'b1;
         end
         acc = sym_valid && sym_ready;
         step();
         if (acc) accepted++;
         cyc++;
      end
      sym_ready = 1'b1;
      rc_exp = rc_exp + 8'd1;
      chk("drain_cycles", 32'(cyc), 32'(16 + stall_cyc));
      chk("drain_accepts", 32'(accepted), 32'd16);
      chk("idle_valid", 32'(sym_valid), 32'd0);
      chk("run_count", 32'(run_count), 32'(rc_exp));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_run(input logic [31:0] v, input int lat, input int stall_sym, input int stall_cyc);
      start_and_finish(v, lat);
      drain(stall_sym, stall_cyc);
   endtask

   initial begin
      int n;
      int starts;
      int last;
      int cd;
      int cyc;
      logic prev_busy;

      fork
         monitor();
      join_none

      // Reset state, waitrequest live during reset
      repeat (3) step();
      stall_i = 1'b1;
      #1 chk("waitreq_in_reset", 32'(waitrequest), 32'd1);
      stall_i = 1'b0;
      #1 chk("waitreq_in_reset0", 32'(waitrequest), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_valid", 32'(sym_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      chk("rst_run_count", 32'(run_count), 32'd0);
      reset = 1'b1;
      step();

      // Basic run: finish 5 cycles after start
      do_run(32'hDEADBEEF, 5, -1, 0);
      chk("basic_busy_low", 32'(busy), 32'd0);

      // Backpressure on symbol 1 for 3 cycles
      do_run(32'h00000004, 2, 1, 3);

      // Finish on the last watchdog cycle still wins
      do_run(32'h0F0F1234, 8, -1, 0);

      // Timeout with no finish
      trigger = 1'b1;
      step();
      chk("to_start", 32'(start), 32'd1);
      trigger = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (!timeout_o && n < 40);
      chk("to_cycles", 32'(n), 32'd9);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_run_count", 32'(run_count), 32'(rc_exp));
      step();
      chk("to_one_cycle", 32'(timeout_o), 32'd0);
      finish = 1'b1;
      return_val = 32'h12345678;
      step();
      finish = 1'b0;
      chk("late_finish_valid", 32'(sym_valid), 32'd0);
      chk("late_finish_busy", 32'(busy), 32'd0);
      step();
      chk("late_finish_valid2", 32'(sym_valid), 32'd0);

      // Trigger held high through three runs with stall_i toggling
      trigger = 1'b1;
      starts = 0;
      last = -1;
      cd = 0;
      cyc = 0;
      prev_busy = busy;
      while (cyc < 150 && !(starts == 3 && !busy && cd == 0)) begin
         stall_i = 1'($urandom_range(0, 1));
         #1 chk("waitreq_mirror", 32'(waitrequest), 32'(stall_i));
         finish = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               finish = 1'b1;
               return_val = 32'hA5A50000 | 32'(starts);
               push_syms(return_val);
            end
         end
         if (start) begin
            starts++;
            chk("start_after_idle", 32'(prev_busy), 32'd0);
            if (last >= 0) chk("start_period", 32'(cyc - last), 32'd21);
            last = cyc;
            cd = 3;
            if (starts == 3) trigger = 1'b0;
         end
         prev_busy = busy;
         step();
         cyc++;
      end
      finish = 1'b0;
      stall_i = 1'b0;
      trigger = 1'b0;
      rc_exp = rc_exp + 8'd3;
      chk("held_starts", 32'(starts), 32'd3);
      chk("held_run_count", 32'(run_count), 32'(rc_exp));
      chk("held_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset after five accepted symbols
      start_and_finish(32'h12345678, 2);
      repeat (5) step();
      reset = 1'b0;
      sym_ready = 1'b0;
      step();
      reset = 1'b1;
      sym_ready = 1'b1;
      exp_q.delete();
      rc_exp = 8'd0;
      chk("mid_rst_valid", 32'(sym_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_run_count", 32'(run_count), 32'd0);
      do_run(32'hFFFFFFFF, 3, -1, 0);

      // Back-to-back runs through the counter wrap
      n = 0;
      while (rc_exp != 8'd255 && n < 300) begin
         do_run(32'h9E3779B9 ^ 32'(n), 1, -1, 0);
         n++;
      end
      chk("rc_255", 32'(run_count), 32'd255);
      do_run(32'h0000C0DE, 1, -1, 0);
      chk("rc_wrap", 32'(run_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
